// File: rtl/id_ctrl_pkg.sv
// Shared definitions for the ID-stage hazard controller.
//   NUM_REGS             architectural register count (x0 is hard-wired zero)
//   REG_IDX_W / reg_idx_t register index width and type
//   DEFAULT_MAX_INFLIGHT default saturation point of a scoreboard counter
//   state_t              controller FSM states
//   cnt_width()          counter width able to hold 0..max_inflight
package id_ctrl_pkg;

    localparam int unsigned NUM_REGS             = 32;
    localparam int unsigned REG_IDX_W            = 5;
    localparam int unsigned DEFAULT_MAX_INFLIGHT = 3;

    typedef logic [REG_IDX_W-1:0] reg_idx_t;

    typedef enum logic [1:0] {
        RUN,
        HOLD,
        MEMWAIT,
        FLUSH
    } state_t;

    function automatic int unsigned cnt_width(input int unsigned max_inflight);
        return (max_inflight < 1) ? 1 : $clog2(max_inflight + 1);
    endfunction

endpackage

// File: rtl/id_hazard_ctrl_if.sv
// Pipeline <-> hazard controller signal bundle.
//   master : pipeline side, drives ID/WB/dmem status, receives control.
//   slave  : controller side, receives status, drives stall/flush/freeze.
interface id_hazard_ctrl_if;
    import id_ctrl_pkg::*;

    logic     ID_valid;
    reg_idx_t ID_rs1;
    reg_idx_t ID_rs2;
    logic     ID_use_rs1;
    logic     ID_use_rs2;
    reg_idx_t ID_rd;
    logic     ID_wr_rd;
    logic     ID_jump;
    reg_idx_t WB_rd;
    logic     WB_load_regfile;
    logic     dmem_busy;

    logic     stall_IF;
    logic     stall_ID;
    logic     bubble_EX;
    logic     flush_IF_ID;
    logic     pc_sel_jmp;
    logic     freeze;

    modport master (
        output ID_valid, ID_rs1, ID_rs2, ID_use_rs1, ID_use_rs2, ID_rd, ID_wr_rd,
               ID_jump, WB_rd, WB_load_regfile, dmem_busy,
        input  stall_IF, stall_ID, bubble_EX, flush_IF_ID, pc_sel_jmp, freeze
    );

    modport slave (
        input  ID_valid, ID_rs1, ID_rs2, ID_use_rs1, ID_use_rs2, ID_rd, ID_wr_rd,
               ID_jump, WB_rd, WB_load_regfile, dmem_busy,
        output stall_IF, stall_ID, bubble_EX, flush_IF_ID, pc_sel_jmp, freeze
    );

endinterface

// File: rtl/id_scoreboard.sv
// Per-register outstanding-write counters.
//   clk, rst_n            clock, async active-low reset (clears all counters)
//   issue_en/issue_idx    increment counter of issue_idx at the edge
//   retire_en/retire_idx  decrement counter of retire_idx at the edge
//   rs1_idx/rs2_idx       queried sources -> rs1_pending/rs2_pending
//   rd_idx                queried destination -> rd_full (at MAX_INFLIGHT)
// Register 0 is never tracked and always reads as empty.
module id_scoreboard
    import id_ctrl_pkg::*;
#(
    parameter int unsigned MAX_INFLIGHT = DEFAULT_MAX_INFLIGHT
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     issue_en,
    input  reg_idx_t issue_idx,
    input  logic     retire_en,
    input  reg_idx_t retire_idx,
    input  reg_idx_t rs1_idx,
    input  reg_idx_t rs2_idx,
    input  reg_idx_t rd_idx,
    output logic     rs1_pending,
    output logic     rs2_pending,
    output logic     rd_full
);

    localparam int unsigned CNT_W = cnt_width(MAX_INFLIGHT);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_INFLIGHT);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0]    cnt [NUM_REGS];
    logic [NUM_REGS-1:0] inc_vec;
    logic [NUM_REGS-1:0] dec_vec;

    always_comb begin
        inc_vec = '0;
        dec_vec = '0;
        if (issue_en && issue_idx != '0) inc_vec[issue_idx] = 1'b1;
        if (retire_en && retire_idx != '0) dec_vec[retire_idx] = 1'b1;
    end

    // A write retiring this cycle is visible through the regfile, so its
    // slot already counts as free for both the pending and full queries.
    always_comb begin
        rs1_pending = (rs1_idx != '0) && (cnt[rs1_idx] != '0) &&
                      !(dec_vec[rs1_idx] && cnt[rs1_idx] == CNT_ONE);
        rs2_pending = (rs2_idx != '0) && (cnt[rs2_idx] != '0) &&
                      !(dec_vec[rs2_idx] && cnt[rs2_idx] == CNT_ONE);
        rd_full     = (rd_idx != '0) && (cnt[rd_idx] == CNT_MAX) && !dec_vec[rd_idx];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) cnt[i] <= '0;
        end else begin
            for (int unsigned i = 1; i < NUM_REGS; i++) begin
                if (inc_vec[i] && !dec_vec[i] && cnt[i] != CNT_MAX)
                    cnt[i] <= cnt[i] + CNT_ONE;
                else if (dec_vec[i] && !inc_vec[i] && cnt[i] != '0)
                    cnt[i] <= cnt[i] - CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            for (int unsigned i = 1; i < NUM_REGS; i++) begin
                if (dec_vec[i] && !inc_vec[i]) assert (cnt[i] != '0);
                if (inc_vec[i] && !dec_vec[i]) assert (cnt[i] != CNT_MAX);
            end
        end
    end

endmodule

// File: rtl/id_hazard_ctrl.sv
// ID-stage hazard controller: scoreboard-based RAW/WAW-depth stalls,
// jump redirect/flush and data-memory freeze.
//   clk, rst_n  clock, async active-low reset (outputs 0 while low)
//   bus         id_hazard_ctrl_if.slave: ID/WB/dmem status in,
//               stall_IF/stall_ID/bubble_EX/flush_IF_ID/pc_sel_jmp/freeze out
module id_hazard_ctrl
    import id_ctrl_pkg::*;
#(
    parameter int unsigned MAX_INFLIGHT = DEFAULT_MAX_INFLIGHT
) (
    input  logic               clk,
    input  logic               rst_n,
    id_hazard_ctrl_if.slave    bus
);

    state_t state_q, state_d;
    logic   id_active, hazard, issue_en, retire_en;
    logic   rs1_pending, rs2_pending, rd_full;

    // Memory stall freezes WB too, so no retire can happen under dmem_busy.
    assign retire_en = rst_n && bus.WB_load_regfile && !bus.dmem_busy;

    id_scoreboard #(.MAX_INFLIGHT(MAX_INFLIGHT)) u_scoreboard (
        .clk         (clk),
        .rst_n       (rst_n),
        .issue_en    (issue_en),
        .issue_idx   (bus.ID_rd),
        .retire_en   (retire_en),
        .retire_idx  (bus.WB_rd),
        .rs1_idx     (bus.ID_rs1),
        .rs2_idx     (bus.ID_rs2),
        .rd_idx      (bus.ID_rd),
        .rs1_pending (rs1_pending),
        .rs2_pending (rs2_pending),
        .rd_full     (rd_full)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= RUN;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d         = state_q;
        bus.stall_IF    = 1'b0;
        bus.stall_ID    = 1'b0;
        bus.bubble_EX   = 1'b0;
        bus.flush_IF_ID = 1'b0;
        bus.pc_sel_jmp  = 1'b0;
        bus.freeze      = 1'b0;
        issue_en        = 1'b0;

        // The slot after a taken jump holds a squashed instruction.
        id_active = bus.ID_valid && (state_q != FLUSH);
        hazard    = id_active && ((bus.ID_use_rs1 && rs1_pending) ||
                                  (bus.ID_use_rs2 && rs2_pending) ||
                                  (bus.ID_wr_rd && rd_full));

        if (!rst_n) begin
            state_d = RUN;
        end else if (bus.dmem_busy) begin
            state_d      = MEMWAIT;
            bus.freeze   = 1'b1;
            bus.stall_IF = 1'b1;
            bus.stall_ID = 1'b1;
        end else if (hazard) begin
            state_d       = HOLD;
            bus.stall_IF  = 1'b1;
            bus.stall_ID  = 1'b1;
            bus.bubble_EX = 1'b1;
        end else begin
            issue_en = id_active && bus.ID_wr_rd;
            if (id_active && bus.ID_jump) begin
                state_d         = FLUSH;
                bus.pc_sel_jmp  = 1'b1;
                bus.flush_IF_ID = 1'b1;
            end else begin
                state_d = RUN;
            end
        end
    end

endmodule

// File: doc/id_hazard_ctrl.md
ID_HAZARD_CTRL -- requirements
Module: id_hazard_ctrl

Interface
REQ-001 Parameter: MAX_INFLIGHT, default 3, maximum outstanding writes per architectural register (counter saturates here).
REQ-002 Clocking: one clock; reset is asynchronous and active-low.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 ID_valid  in  1  ID holds a real instruction.
REQ-006 ID_rs1, ID_rs2  in  5 each  source register indices.
REQ-007 ID_use_rs1, ID_use_rs2  in  1 each  instruction reads that source.
REQ-008 ID_rd  in  5  destination index.
REQ-009 ID_wr_rd  in  1  instruction writes ID_rd.
REQ-010 ID_jump  in  1  ID resolves a taken branch/jump (ID_jmp_pc valid).
REQ-011 WB_rd  in  5  retiring destination index.
REQ-012 WB_load_regfile  in  1  regfile write this cycle.
REQ-013 dmem_busy  in  1  data memory not ready; whole pipeline must freeze.
REQ-014 stall_IF, stall_ID  out  1 each  hold PC and IF/ID register.
REQ-015 bubble_EX  out  1  insert NOP into ID/EX.
REQ-016 flush_IF_ID  out  1  squash the fetched instruction.
REQ-017 pc_sel_jmp  out  1  select ID_jmp_pc as next PC.
REQ-018 freeze  out  1  hold EX/MEM/WB registers.

Function
REQ-019 Scoreboard: 32 counters, width ceil(log2(MAX_INFLIGHT+1)); register 0 never tracked, always reads 0.
REQ-020 Issue (ID_valid, ID_wr_rd, ID_rd!=0, no stall/freeze/flush this cycle) increments counter[ID_rd] at the clock edge.
REQ-021 Retire (WB_load_regfile, WB_rd!=0, freeze=0) decrements counter[WB_rd]; issue and retire of same register in one cycle leave it unchanged.
REQ-022 Hazard = ID_valid and ((ID_use_rs1 and rs1 pending) or (ID_use_rs2 and rs2 pending) or (ID_wr_rd and counter[ID_rd]==MAX_INFLIGHT)); a register retiring this cycle with count 1 is not pending (WB-to-ID bypass through regfile).
REQ-023 FSM states RUN, HOLD, MEMWAIT, FLUSH; reset state RUN.
REQ-024 Priority each cycle: dmem_busy > hazard > ID_jump > normal.
REQ-025 Any state, dmem_busy=1: next MEMWAIT; freeze, stall_IF, stall_ID =1; scoreboard unchanged; bubble_EX=0.
REQ-026 MEMWAIT, dmem_busy=0: next RUN if no hazard, else HOLD; outputs follow REQ-027..029 in that cycle.
REQ-027 RUN/HOLD with hazard: next HOLD; stall_IF=stall_ID=bubble_EX=1; jump suppressed (jalr operand not ready).
REQ-028 RUN/HOLD, no hazard, ID_jump: pc_sel_jmp=1, flush_IF_ID=1 same cycle, issue allowed; next FLUSH.
REQ-029 FLUSH: one cycle, ID treated as invalid (no issue, no hazard, flush_IF_ID=0); next RUN, or MEMWAIT if dmem_busy.
REQ-030 All outputs are combinational from state and current inputs; no added latency; stall outputs become 0 in the same cycle the last blocking counter reaches 0.
REQ-031 Counter underflow (retire at 0) and overflow are design errors: counter holds value, simulation assertion fires.

Reset
REQ-032 rst_n low: state RUN, all counters 0, immediately; all outputs 0 while rst_n low.
REQ-033 Reset mid-stall or mid-MEMWAIT discards all pending state; first cycle after release behaves as RUN with empty scoreboard.

Structure
REQ-034 Package id_ctrl_pkg holds the state enum, NUM_REGS=32, and the counter width function/constant.
REQ-035 Sub-module id_scoreboard holds the 32 counters, issue/retire ports, and pending query for three indices; FSM and output decode stay in id_hazard_ctrl.

Verification
REQ-036 Load x5 issued, next instr reads x5 -> stall_ID=bubble_EX=1 until WB_rd=5 retires, released same cycle.
REQ-037 ID_jump=1, no hazard -> pc_sel_jmp=flush_IF_ID=1 one cycle, state FLUSH then RUN.
REQ-038 jalr reading x7 while x7 pending plus ID_jump=1 -> pc_sel_jmp=0, HOLD; jump taken cycle x7 clears.
REQ-039 dmem_busy=1 for 4 cycles during HOLD -> freeze=1 for 4 cycles, counters unchanged, returns to HOLD.
REQ-040 Three back-to-back writes to x3, then fourth write to x3 -> fourth stalls until one retires; simultaneous issue+retire x3 keeps count 3.
REQ-041 rst_n asserted in MEMWAIT with counters nonzero -> all outputs 0, scoreboard empty, no stall after release.
